// File: rtl/dla_pe_result_lane_serializer_if.sv
// Bundle for the PE result serializer: valid-only word input, ready/valid beat
// output, and the credit/overflow sideband. The serializer sits on the slave modport.
interface dla_pe_result_lane_serializer_if #(
    parameter int NUM_LANES       = 4,
    parameter int LANE_W          = 512,
    parameter int LANES_PER_BEAT  = 1,
    parameter int RESULT_ID_WIDTH = 4
);
    localparam int BEATS = NUM_LANES / LANES_PER_BEAT;
    localparam int AL_W  = $clog2(NUM_LANES + 1);
    localparam int BI_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                                i_valid;
    logic [NUM_LANES*LANE_W-1:0]         i_result;
    logic [RESULT_ID_WIDTH-1:0]          i_result_id;
    logic [AL_W-1:0]                     i_active_lanes;
    logic                                o_almost_full;
    logic                                o_valid;
    logic                                i_ready;
    logic [LANES_PER_BEAT*LANE_W-1:0]    o_data;
    logic [RESULT_ID_WIDTH-1:0]          o_result_id;
    logic [BI_W-1:0]                     o_beat_index;
    logic                                o_last;
    logic                                o_overflow;
    logic                                i_clear_overflow;

    modport master (
        output i_valid, i_result, i_result_id, i_active_lanes, i_ready, i_clear_overflow,
        input  o_almost_full, o_valid, o_data, o_result_id, o_beat_index, o_last, o_overflow
    );

    modport slave (
        input  i_valid, i_result, i_result_id, i_active_lanes, i_ready, i_clear_overflow,
        output o_almost_full, o_valid, o_data, o_result_id, o_beat_index, o_last, o_overflow
    );
endinterface

// File: rtl/dla_pe_result_lane_serializer.sv
// Buffers full-width PE result words in a small FIFO and replays each one as
// ceil(active_lanes/LANES_PER_BEAT) ready/valid beats, with credit and sticky overflow.
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_EMPTY  | FIFO empty, o_valid low
// ST_STREAM | head word presented, one beat per i_ready cycle
module dla_pe_result_lane_serializer #(
    parameter int NUM_LANES             = 4,
    parameter int NUM_RESULTS_PER_CYCLE = 1,
    parameter int NUM_FEATURES          = 16,
    parameter int RESULT_WIDTH          = 32,
    parameter int LANES_PER_BEAT        = 1,
    parameter int RESULT_ID_WIDTH       = 4,
    parameter int FIFO_DEPTH            = 4,
    parameter int ALMOST_FULL_SLACK     = 2
) (
    input  logic clk,
    input  logic i_aresetn,
    dla_pe_result_lane_serializer_if.slave bus
);
    localparam int LANE_W = NUM_RESULTS_PER_CYCLE * NUM_FEATURES * RESULT_WIDTH;
    localparam int WORD_W = NUM_LANES * LANE_W;
    localparam int BEAT_W = LANES_PER_BEAT * LANE_W;
    localparam int BEATS  = NUM_LANES / LANES_PER_BEAT;
    localparam int AL_W   = $clog2(NUM_LANES + 1);
    localparam int BI_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic {ST_EMPTY, ST_STREAM} state_t;

    logic [WORD_W-1:0]          mem_result [FIFO_DEPTH];
    logic [RESULT_ID_WIDTH-1:0] mem_id     [FIFO_DEPTH];
    logic [AL_W-1:0]            mem_al     [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [BI_W-1:0]  beat_cnt;
    state_t           state;
    logic             valid_q;
    logic             almost_full_q;
    logic             overflow_q;

    logic [AL_W-1:0]   wr_al;
    logic [AL_W-1:0]   head_al;
    logic [WORD_W-1:0] head_word;
    logic [BEAT_W-1:0] beat_data;
    logic              wr_req;
    logic              wr_en;
    logic              full;
    logic              pop_beat;
    logic              pop_word;
    logic              is_last;
    logic              ovf_set;
    int                head_last_beat;
    int                lane_idx;

    always_comb begin
        wr_al          = (bus.i_active_lanes > AL_W'(NUM_LANES)) ? AL_W'(NUM_LANES)
                                                                  : bus.i_active_lanes;
        head_al        = mem_al[rd_ptr];
        head_word      = mem_result[rd_ptr];
        head_last_beat = (int'(head_al) + LANES_PER_BEAT - 1) / LANES_PER_BEAT - 1;
        is_last        = (int'(beat_cnt) == head_last_beat);
        full           = (count == CNT_W'(FIFO_DEPTH));
        pop_beat       = valid_q && bus.i_ready;
        pop_word       = pop_beat && is_last;
        wr_req         = bus.i_valid && (wr_al != '0);
        // A full FIFO still takes a word when the head's last beat leaves this cycle.
        wr_en          = wr_req && (!full || pop_word);
        ovf_set        = wr_req && full && !pop_word;
        count_nxt      = count + CNT_W'(wr_en) - CNT_W'(pop_word);
    end

    // Beat mux: lanes past the word's active count are zeroed.
    always_comb begin
        beat_data = '0;
        lane_idx  = 0;
        for (int l = 0; l < LANES_PER_BEAT; l++) begin
            lane_idx = int'(beat_cnt) * LANES_PER_BEAT + l;
            if (valid_q && lane_idx < int'(head_al) && lane_idx < NUM_LANES)
                beat_data[l*LANE_W +: LANE_W] = head_word[lane_idx*LANE_W +: LANE_W];
        end
    end

    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_result[i] <= '0;
                mem_id[i]     <= '0;
                mem_al[i]     <= '0;
            end
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            beat_cnt      <= '0;
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_result[wr_ptr] <= bus.i_result;
                mem_id[wr_ptr]     <= bus.i_result_id;
                mem_al[wr_ptr]     <= wr_al;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            if (pop_word)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (pop_beat)
                beat_cnt <= is_last ? '0 : beat_cnt + BI_W'(1);
            count         <= count_nxt;
            almost_full_q <= (CNT_W'(FIFO_DEPTH) - count_nxt) <= CNT_W'(ALMOST_FULL_SLACK);
            if (ovf_set)
                overflow_q <= 1'b1;
            else if (bus.i_clear_overflow)
                overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (count_nxt != '0) begin
                        state   <= ST_STREAM;
                        valid_q <= 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (pop_word && count_nxt == '0) begin
                        state   <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_valid       = valid_q;
    assign bus.o_data        = beat_data;
    assign bus.o_result_id   = valid_q ? mem_id[rd_ptr] : '0;
    assign bus.o_beat_index  = beat_cnt;
    assign bus.o_last        = valid_q && is_last;
    assign bus.o_almost_full = almost_full_q;
    assign bus.o_overflow    = overflow_q;
endmodule

// File: tb/tb_dla_pe_result_lane_serializer.sv
// Directed bench: one serializer with 1 lane per beat and one with 2 lanes per beat,
// both with 8-bit lanes so beat data is easy to compute by hand.
module tb_dla_pe_result_lane_serializer;
    localparam logic [31:0] W_ABCD = 32'h0D0C0B0A;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dla_pe_result_lane_serializer_if #(.NUM_LANES(4), .LANE_W(8), .LANES_PER_BEAT(1),
                                       .RESULT_ID_WIDTH(4)) b1 ();
    dla_pe_result_lane_serializer_if #(.NUM_LANES(4), .LANE_W(8), .LANES_PER_BEAT(2),
                                       .RESULT_ID_WIDTH(4)) b2 ();

    dla_pe_result_lane_serializer #(
        .NUM_LANES(4), .NUM_RESULTS_PER_CYCLE(1), .NUM_FEATURES(1), .RESULT_WIDTH(8),
        .LANES_PER_BEAT(1), .RESULT_ID_WIDTH(4), .FIFO_DEPTH(4), .ALMOST_FULL_SLACK(2)
    ) u1 (.clk(clk), .i_aresetn(rst_n), .bus(b1.slave));

    dla_pe_result_lane_serializer #(
        .NUM_LANES(4), .NUM_RESULTS_PER_CYCLE(1), .NUM_FEATURES(1), .RESULT_WIDTH(8),
        .LANES_PER_BEAT(2), .RESULT_ID_WIDTH(4), .FIFO_DEPTH(4), .ALMOST_FULL_SLACK(2)
    ) u2 (.clk(clk), .i_aresetn(rst_n), .bus(b2.slave));

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        b1.i_valid = 1'b0; b1.i_result = '0; b1.i_result_id = '0; b1.i_active_lanes = '0;
        b1.i_ready = 1'b1; b1.i_clear_overflow = 1'b0;
        b2.i_valid = 1'b0; b2.i_result = '0; b2.i_result_id = '0; b2.i_active_lanes = '0;
        b2.i_ready = 1'b1; b2.i_clear_overflow = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) cyc();
        n_cmp++; if (b1.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", b1.o_valid); end
        n_cmp++; if (b1.o_almost_full !== 1'b0) begin n_err++; $display("FAIL reset_almost_full: got %b want 0", b1.o_almost_full); end
        n_cmp++; if (b1.o_overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", b1.o_overflow); end
        n_cmp++; if (b1.o_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", b1.o_last); end
        n_cmp++; if (b1.o_beat_index !== 2'd0) begin n_err++; $display("FAIL reset_beat_index: got %0d want 0", b1.o_beat_index); end
        n_cmp++; if (b1.o_result_id !== 4'd0) begin n_err++; $display("FAIL reset_result_id: got %0d want 0", b1.o_result_id); end
        n_cmp++; if (b1.o_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", b1.o_data); end
        n_cmp++; if (b2.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_b2: got %b want 0", b2.o_valid); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic;
        logic [7:0] exp_d;
        logic       exp_l;
        b1.i_valid = 1'b1; b1.i_result = W_ABCD; b1.i_result_id = 4'd3;
        b1.i_active_lanes = 3'd4; b1.i_ready = 1'b1;
        cyc();
        b1.i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_d = 8'h0A + 8'(k);
            exp_l = (k == 3);
            n_cmp++; if (b1.o_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid beat %0d: got %b want 1", k, b1.o_valid); end
            n_cmp++; if (b1.o_data !== exp_d) begin n_err++; $display("FAIL basic_data beat %0d: got %h want %h", k, b1.o_data, exp_d); end
            n_cmp++; if (b1.o_beat_index !== 2'(k)) begin n_err++; $display("FAIL basic_beat_index beat %0d: got %0d want %0d", k, b1.o_beat_index, k); end
            n_cmp++; if (b1.o_last !== exp_l) begin n_err++; $display("FAIL basic_last beat %0d: got %b want %b", k, b1.o_last, exp_l); end
            n_cmp++; if (b1.o_result_id !== 4'd3) begin n_err++; $display("FAIL basic_id beat %0d: got %0d want 3", k, b1.o_result_id); end
            cyc();
        end
        n_cmp++; if (b1.o_valid !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %b want 0", b1.o_valid); end
    endtask

    task automatic test_partial;
        b2.i_valid = 1'b1; b2.i_result = W_ABCD; b2.i_result_id = 4'd5;
        b2.i_active_lanes = 3'd3; b2.i_ready = 1'b1;
        cyc();
        b2.i_valid = 1'b0;
        n_cmp++; if (b2.o_data !== 16'h0B0A) begin n_err++; $display("FAIL partial_beat0_data: got %h want 0b0a", b2.o_data); end
        n_cmp++; if (b2.o_last !== 1'b0) begin n_err++; $display("FAIL partial_beat0_last: got %b want 0", b2.o_last); end
        n_cmp++; if (b2.o_result_id !== 4'd5) begin n_err++; $display("FAIL partial_id: got %0d want 5", b2.o_result_id); end
        cyc();
        n_cmp++; if (b2.o_data !== 16'h000C) begin n_err++; $display("FAIL partial_beat1_data: got %h want 000c", b2.o_data); end
        n_cmp++; if (b2.o_beat_index !== 1'b1) begin n_err++; $display("FAIL partial_beat1_index: got %0d want 1", b2.o_beat_index); end
        n_cmp++; if (b2.o_last !== 1'b1) begin n_err++; $display("FAIL partial_beat1_last: got %b want 1", b2.o_last); end
        cyc();
        n_cmp++; if (b2.o_valid !== 1'b0) begin n_err++; $display("FAIL partial_idle: got %b want 0", b2.o_valid); end
        // zero active lanes: discarded
        b2.i_valid = 1'b1; b2.i_result_id = 4'd7; b2.i_active_lanes = 3'd0;
        cyc();
        b2.i_valid = 1'b0;
        n_cmp++; if (b2.o_valid !== 1'b0) begin n_err++; $display("FAIL zero_lanes_valid: got %b want 0", b2.o_valid); end
        cyc();
        n_cmp++; if (b2.o_valid !== 1'b0) begin n_err++; $display("FAIL zero_lanes_valid_late: got %b want 0", b2.o_valid); end
        n_cmp++; if (b2.o_almost_full !== 1'b0) begin n_err++; $display("FAIL zero_lanes_almost_full: got %b want 0", b2.o_almost_full); end
        // active lanes above NUM_LANES behaves as a full word
        b2.i_valid = 1'b1; b2.i_result_id = 4'd8; b2.i_active_lanes = 3'd7;
        cyc();
        b2.i_valid = 1'b0;
        n_cmp++; if (b2.o_data !== 16'h0B0A) begin n_err++; $display("FAIL clamp_beat0_data: got %h want 0b0a", b2.o_data); end
        cyc();
        n_cmp++; if (b2.o_data !== 16'h0D0C) begin n_err++; $display("FAIL clamp_beat1_data: got %h want 0d0c", b2.o_data); end
        n_cmp++; if (b2.o_last !== 1'b1) begin n_err++; $display("FAIL clamp_beat1_last: got %b want 1", b2.o_last); end
        cyc();
        n_cmp++; if (b2.o_valid !== 1'b0) begin n_err++; $display("FAIL clamp_idle: got %b want 0", b2.o_valid); end
    endtask

    task automatic test_back_to_back;
        b2.i_valid = 1'b1; b2.i_result = W_ABCD; b2.i_result_id = 4'd1;
        b2.i_active_lanes = 3'd4; b2.i_ready = 1'b1;
        cyc();
        b2.i_result = 32'h66666655; b2.i_result_id = 4'd2; b2.i_active_lanes = 3'd1;
        n_cmp++; if (b2.o_data !== 16'h0B0A || b2.o_result_id !== 4'd1) begin n_err++; $display("FAIL b2b_w1_beat0: got %h/%0d want 0b0a/1", b2.o_data, b2.o_result_id); end
        cyc();
        b2.i_valid = 1'b0;
        n_cmp++; if (b2.o_data !== 16'h0D0C || b2.o_last !== 1'b1) begin n_err++; $display("FAIL b2b_w1_beat1: got %h/%b want 0d0c/1", b2.o_data, b2.o_last); end
        cyc();
        n_cmp++; if (b2.o_valid !== 1'b1 || b2.o_result_id !== 4'd2) begin n_err++; $display("FAIL b2b_w2_no_bubble: got %b/%0d want 1/2", b2.o_valid, b2.o_result_id); end
        n_cmp++; if (b2.o_data !== 16'h0055) begin n_err++; $display("FAIL b2b_w2_data: got %h want 0055", b2.o_data); end
        n_cmp++; if (b2.o_last !== 1'b1 || b2.o_beat_index !== 1'b0) begin n_err++; $display("FAIL b2b_w2_last: got %b/%0d want 1/0", b2.o_last, b2.o_beat_index); end
        cyc();
        n_cmp++; if (b2.o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", b2.o_valid); end
    endtask

    task automatic test_backpressure;
        int         r_seq [6] = '{1, 0, 0, 1, 1, 1};
        int         e_seq [6] = '{0, 1, 1, 1, 2, 3};
        logic [7:0] exp_d;
        logic       exp_l;
        b1.i_valid = 1'b1; b1.i_result = W_ABCD; b1.i_result_id = 4'd6;
        b1.i_active_lanes = 3'd4; b1.i_ready = 1'b1;
        cyc();
        b1.i_valid = 1'b0;
        for (int t = 0; t < 6; t++) begin
            exp_d = 8'h0A + 8'(e_seq[t]);
            exp_l = (e_seq[t] == 3);
            n_cmp++; if (b1.o_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid t%0d: got %b want 1", t, b1.o_valid); end
            n_cmp++; if (b1.o_beat_index !== 2'(e_seq[t])) begin n_err++; $display("FAIL bp_beat_index t%0d: got %0d want %0d", t, b1.o_beat_index, e_seq[t]); end
            n_cmp++; if (b1.o_data !== exp_d) begin n_err++; $display("FAIL bp_data t%0d: got %h want %h", t, b1.o_data, exp_d); end
            n_cmp++; if (b1.o_last !== exp_l || b1.o_result_id !== 4'd6) begin n_err++; $display("FAIL bp_last_id t%0d: got %b/%0d want %b/6", t, b1.o_last, b1.o_result_id, exp_l); end
            b1.i_ready = (r_seq[t] != 0);
            cyc();
        end
        n_cmp++; if (b1.o_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b want 0", b1.o_valid); end
        b1.i_ready = 1'b1;
    endtask

    task automatic test_fill_overflow;
        logic exp_af;
        logic exp_ov;
        b1.i_ready = 1'b0;
        for (int w = 1; w <= 5; w++) begin
            b1.i_valid = 1'b1; b1.i_result = {24'hEEEEEE, 8'h10 + 8'(w)};
            b1.i_result_id = 4'(w); b1.i_active_lanes = 3'd1;
            cyc();
            exp_af = (w >= 2);
            exp_ov = (w == 5);
            n_cmp++; if (b1.o_almost_full !== exp_af) begin n_err++; $display("FAIL fill_almost_full w%0d: got %b want %b", w, b1.o_almost_full, exp_af); end
            n_cmp++; if (b1.o_overflow !== exp_ov) begin n_err++; $display("FAIL fill_overflow w%0d: got %b want %b", w, b1.o_overflow, exp_ov); end
        end
        b1.i_valid = 1'b0;
        n_cmp++; if (b1.o_result_id !== 4'd1) begin n_err++; $display("FAIL fill_head_id: got %0d want 1", b1.o_result_id); end
        b1.i_clear_overflow = 1'b1;
        cyc();
        b1.i_clear_overflow = 1'b0;
        n_cmp++; if (b1.o_overflow !== 1'b0) begin n_err++; $display("FAIL clear_overflow: got %b want 0", b1.o_overflow); end
        b1.i_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            n_cmp++; if (b1.o_valid !== 1'b1 || b1.o_result_id !== 4'(w)) begin n_err++; $display("FAIL drain_id %0d: got %b/%0d want 1/%0d", w, b1.o_valid, b1.o_result_id, w); end
            n_cmp++; if (b1.o_data !== 8'h10 + 8'(w) || b1.o_last !== 1'b1) begin n_err++; $display("FAIL drain_data %0d: got %h/%b want %h/1", w, b1.o_data, b1.o_last, 8'h10 + 8'(w)); end
            cyc();
        end
        n_cmp++; if (b1.o_valid !== 1'b0) begin n_err++; $display("FAIL drain_dropped_word: got valid %b want 0", b1.o_valid); end
        n_cmp++; if (b1.o_almost_full !== 1'b0) begin n_err++; $display("FAIL drain_almost_full: got %b want 0", b1.o_almost_full); end
    endtask

    task automatic test_simul_full;
        int exp_ids [4] = '{2, 3, 4, 9};
        b1.i_ready = 1'b0;
        for (int w = 1; w <= 4; w++) begin
            b1.i_valid = 1'b1; b1.i_result = {24'h0, 8'h20 + 8'(w)};
            b1.i_result_id = 4'(w); b1.i_active_lanes = 3'd1;
            cyc();
        end
        n_cmp++; if (b1.o_almost_full !== 1'b1) begin n_err++; $display("FAIL full_almost_full: got %b want 1", b1.o_almost_full); end
        b1.i_ready = 1'b1; b1.i_result = {24'h0, 8'h29}; b1.i_result_id = 4'd9;
        cyc();
        b1.i_valid = 1'b0;
        n_cmp++; if (b1.o_overflow !== 1'b0) begin n_err++; $display("FAIL simul_overflow: got %b want 0", b1.o_overflow); end
        n_cmp++; if (b1.o_almost_full !== 1'b1) begin n_err++; $display("FAIL simul_almost_full: got %b want 1", b1.o_almost_full); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (b1.o_valid !== 1'b1 || b1.o_result_id !== 4'(exp_ids[i])) begin n_err++; $display("FAIL simul_order %0d: got %b/%0d want 1/%0d", i, b1.o_valid, b1.o_result_id, exp_ids[i]); end
            n_cmp++; if (b1.o_data !== 8'h20 + 8'(exp_ids[i])) begin n_err++; $display("FAIL simul_data %0d: got %h want %h", i, b1.o_data, 8'h20 + 8'(exp_ids[i])); end
            cyc();
        end
        n_cmp++; if (b1.o_valid !== 1'b0) begin n_err++; $display("FAIL simul_idle: got %b want 0", b1.o_valid); end
    endtask

    task automatic test_reset_mid;
        b1.i_ready = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            b1.i_valid = 1'b1; b1.i_result = W_ABCD; b1.i_result_id = 4'(w);
            b1.i_active_lanes = 3'd4;
            cyc();
        end
        b1.i_valid = 1'b0;
        b1.i_ready = 1'b1;
        cyc();
        cyc();
        n_cmp++; if (b1.o_beat_index !== 2'd2 || b1.o_almost_full !== 1'b1) begin n_err++; $display("FAIL midrst_pre: got idx %0d af %b want 2/1", b1.o_beat_index, b1.o_almost_full); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (b1.o_valid !== 1'b0 || b1.o_last !== 1'b0) begin n_err++; $display("FAIL midrst_valid_last: got %b/%b want 0/0", b1.o_valid, b1.o_last); end
        n_cmp++; if (b1.o_beat_index !== 2'd0 || b1.o_result_id !== 4'd0) begin n_err++; $display("FAIL midrst_idx_id: got %0d/%0d want 0/0", b1.o_beat_index, b1.o_result_id); end
        n_cmp++; if (b1.o_data !== 8'h00 || b1.o_almost_full !== 1'b0) begin n_err++; $display("FAIL midrst_data_af: got %h/%b want 00/0", b1.o_data, b1.o_almost_full); end
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (b1.o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_no_resume %0d: got %b want 0", i, b1.o_valid); end
        end
        b1.i_valid = 1'b1; b1.i_result = W_ABCD; b1.i_result_id = 4'd11; b1.i_active_lanes = 3'd4;
        cyc();
        b1.i_valid = 1'b0;
        n_cmp++; if (b1.o_valid !== 1'b1 || b1.o_result_id !== 4'd11 || b1.o_data !== 8'h0A) begin n_err++; $display("FAIL midrst_new_word: got %b/%0d/%h want 1/11/0a", b1.o_valid, b1.o_result_id, b1.o_data); end
        repeat (4) cyc();
        n_cmp++; if (b1.o_valid !== 1'b0) begin n_err++; $display("FAIL midrst_final_idle: got %b want 0", b1.o_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_partial();
        test_back_to_back();
        test_backpressure();
        test_fill_overflow();
        test_simul_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dla_pe_result_lane_serializer.md
# dla_pe_result_lane_serializer

Buffers full-width PE-array result words and re-emits them as a narrower ready/valid stream of `LANES_PER_BEAT` lanes per beat. It sits between the PE array result output, which is valid-only with no backpressure, and the downstream activation/pool path. It generalises the fixed-width result transfer with four additions: a parametrised beat width, a per-word active-lane count, FIFO buffering with an early-stall credit signal, and sticky overflow detection.

## Interface
Parameters:
- `NUM_LANES`, 4: lanes per input word.
- `NUM_RESULTS_PER_CYCLE`, 1: results per lane.
- `NUM_FEATURES`, 16: features per result.
- `RESULT_WIDTH`, 32: bits per feature.
- `LANES_PER_BEAT`, 1: lanes per output beat. Must divide `NUM_LANES`.
- `RESULT_ID_WIDTH`, 4: width of the tag carried with each word.
- `FIFO_DEPTH`, 4: input words buffered. Power of 2, at least 2.
- `ALMOST_FULL_SLACK`, 2: free entries remaining when `o_almost_full` asserts. Range 1 to `FIFO_DEPTH`.
- Derived values:
  - `LANE_W` = `NUM_RESULTS_PER_CYCLE*NUM_FEATURES*RESULT_WIDTH`
  - `BEATS` = `NUM_LANES/LANES_PER_BEAT`
  - `AL_W` = `$clog2(NUM_LANES+1)`

Ports:
- `clk`  in  1  clock.
- `i_aresetn`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  input word valid. There is no backpressure on this side.
- `i_result`  in  `NUM_LANES*LANE_W`  input word. Lane 0 is in the LSBs.
- `i_result_id`  in  `RESULT_ID_WIDTH`  tag for the word.
- `i_active_lanes`  in  `AL_W`  number of valid lanes, counted from lane 0.
- `o_almost_full`  out  1  asserted when free entries ≤ `ALMOST_FULL_SLACK`.
- `o_valid`  out  1  output beat valid.
- `i_ready`  in  1  downstream ready.
- `o_data`  out  `LANES_PER_BEAT*LANE_W`  beat data.
- `o_result_id`  out  `RESULT_ID_WIDTH`  tag of the current word.
- `o_beat_index`  out  `$clog2(BEATS)` (minimum 1)  beat number within the word.
- `o_last`  out  1  final beat of the word.
- `o_overflow`  out  1  sticky overflow flag.
- `i_clear_overflow`  in  1  synchronous clear for `o_overflow`.

## Operation
**Write side**
- Writes occur when `i_valid=1` and `i_active_lanes≠0`.
- Each write stores {result, id, active_lanes} at the write pointer and increments the pointer modulo `FIFO_DEPTH`.
- `i_valid=1` with `i_active_lanes=0` is discarded. Nothing is written and the overflow flag is not affected.
- `i_active_lanes > NUM_LANES` is treated as `NUM_LANES`.

**Full handling**
- When the FIFO is full, a write is accepted only if the head word's final beat pops in the same cycle.
- Otherwise the word is dropped and `o_overflow` is set. It stays set until `i_clear_overflow=1`.
- If set and clear occur in the same cycle, set wins.

**Read side**
- The head word emits `NB` = ceil(`active_lanes`/`LANES_PER_BEAT`) beats.
- Beat k carries lanes `k*LANES_PER_BEAT` to `k*LANES_PER_BEAT+LANES_PER_BEAT-1`.
- Lanes at or beyond `active_lanes` within the final beat are driven to zero.
- The beat counter advances on `o_valid && i_ready`.
- On the handshake of beat `NB-1`:
  - `o_last=1`;
  - the counter returns to 0;
  - the read pointer advances.

**Control state machine**
- State EMPTY: `o_valid=0`. Moves to STREAM when the FIFO count becomes nonzero.
- State STREAM: `o_valid=1`. On a final-beat pop, moves to EMPTY if the count becomes 0, otherwise stays in STREAM with the counter at 0.

**Output stability**
- While `o_valid=1 && i_ready=0`, the values of `o_data`, `o_result_id`, `o_beat_index` and `o_last` are held stable.

**Pass-through configuration**
- With `LANES_PER_BEAT=NUM_LANES`, every word is a single beat with `o_last=1`, and the block degenerates to a FIFO.

**Count and credit**
- The count is held in a `$clog2(FIFO_DEPTH)+1`-bit counter.
- Writes and pops in the same cycle leave the count unchanged.
- `o_almost_full` is registered and computed from the next-state count.

## Timing
- Values after reset:
  - `o_valid=0`
  - `o_almost_full=0`
  - `o_overflow=0`
  - `o_last=0`
  - `o_beat_index=0`
  - `o_result_id=0`
  - `o_data=0`
  - pointers, count and beat counter = 0
- Latency: a word written at edge N produces `o_valid=1` in the cycle after edge N, so first-beat latency is 1 cycle.
- Throughput: one beat per cycle while `i_ready=1`. Consecutive words stream with no bubble.
- `o_almost_full` updates on the edge that changes the count. Upstream must stall within `ALMOST_FULL_SLACK` cycles of seeing it.
- Reset assertion mid-word clears all state asynchronously. Buffered words are lost and no partial beats resume after release.
- Output data comes from a registered FIFO through the beat mux. No combinational path runs from `i_result` to `o_data`.
- There is no combinational path from `i_ready` to `o_valid`.

## Test plan
- **Basic serialisation.** Config `NUM_LANES=4`, `LANES_PER_BEAT=1`, `i_ready=1`. Write one word with lanes 0xA..0xD and id 3.
  - Expect 4 beats in consecutive cycles starting 1 cycle after the write.
  - `o_data` A, B, C, D; `o_beat_index` 0–3; `o_last` only on beat 3; `o_result_id=3` throughout.
- **Partial lanes.** Config `LANES_PER_BEAT=2`, `i_active_lanes=3`.
  - Expect 2 beats: beat 1 carries lane 2 in its low half and zero in its high half, with `o_last=1`.
  - A word with `i_active_lanes=0` produces no beats and leaves the count at 0.
- **Backpressure.** Toggle `i_ready` in the pattern 1,0,0,1 mid-word.
  - Outputs stay stable while stalled.
  - No beat is duplicated or skipped.
- **Fill and overflow.** With `FIFO_DEPTH=4` and `i_ready=0`, write 5 words.
  - `o_almost_full` rises after the 2nd write.
  - The 5th write sets `o_overflow`; the drop of that word is confirmed by the 4 words draining in order.
  - Then pulse `i_clear_overflow` and confirm it clears.
- **Simultaneous write on full.** Fill the FIFO, then write in the same cycle as a final-beat pop.
  - No overflow; the count stays 4; the new word emerges last.
- **Reset mid-stream.** Assert `i_aresetn=0` during beat 2 of a word holding 3 buffered words.
  - All outputs take their reset values immediately.
  - After release `o_valid` stays 0 until a new write.
